// File: rtl/tag_data_array.sv
// One-hot addressed tag+data array with per-entry valid bits, registered reads
// with tag-compare hit, single-entry invalidate, flush sweep and wordline checking.
//
// state | meaning
// IDLE  | accepting accesses; flush request starts a sweep
// SWEEP | clearing one valid bit per cycle, accesses ignored
module tag_data_array #(
  parameter int DEPTH  = 16,
  parameter int TAG_W  = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic              inv,
  input  logic              flush,
  input  logic [DEPTH-1:0]  wl,
  input  logic [TAG_W-1:0]  tag_in,
  input  logic [DATA_W-1:0] data_in,
  output logic [TAG_W-1:0]  tag_out,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  output logic              hit,
  output logic              rd_valid,
  output logic              wl_err,
  output logic              busy
);

  localparam int IDX_W = $clog2(DEPTH);

  typedef enum logic {IDLE, SWEEP} state_t;

  state_t             state;
  logic [IDX_W-1:0]   flush_idx;
  logic [DEPTH-1:0]   valid;
  logic [TAG_W-1:0]   tag_mem  [DEPTH];
  logic [DATA_W-1:0]  data_mem [DEPTH];

  logic               wl_seen;
  logic               wl_multi;
  logic               wl_onehot;
  logic [IDX_W-1:0]   idx;
  logic               legal;
  logic               mem_wr;

  always_comb begin
    wl_seen  = 1'b0;
    wl_multi = 1'b0;
    idx      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (wl[i]) begin
        if (wl_seen) wl_multi = 1'b1;
        wl_seen = 1'b1;
        idx     = idx | IDX_W'(i);
      end
    end
    wl_onehot = wl_seen & ~wl_multi;
  end

  // A flush request in IDLE takes precedence over any access in the same cycle.
  assign legal  = (state == IDLE) && !flush && wl_onehot;
  assign mem_wr = legal && we && !inv;

  // Array contents are deliberately not reset; only valid bits gate their use.
  always_ff @(posedge clk) begin
    if (mem_wr) begin
      tag_mem[idx]  <= tag_in;
      data_mem[idx] <= data_in;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      flush_idx <= '0;
      valid     <= '0;
      busy      <= 1'b0;
      tag_out   <= '0;
      data_out  <= '0;
      valid_out <= 1'b0;
      hit       <= 1'b0;
      rd_valid  <= 1'b0;
      wl_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (flush) begin
            state     <= SWEEP;
            busy      <= 1'b1;
            flush_idx <= '0;
            rd_valid  <= 1'b0;
            wl_err    <= 1'b0;
            hit       <= 1'b0;
          end else if (wl_onehot) begin
            rd_valid <= 1'b1;
            wl_err   <= 1'b0;
            if (inv) begin
              valid[idx] <= 1'b0;
              tag_out    <= tag_mem[idx];
              data_out   <= data_mem[idx];
              valid_out  <= 1'b0;
              hit        <= 1'b0;
            end else if (we) begin
              valid[idx] <= 1'b1;
              tag_out    <= tag_in;
              data_out   <= data_in;
              valid_out  <= 1'b1;
              hit        <= 1'b1;
            end else begin
              tag_out   <= tag_mem[idx];
              data_out  <= data_mem[idx];
              valid_out <= valid[idx];
              hit       <= valid[idx] && (tag_mem[idx] == tag_in);
            end
          end else begin
            wl_err    <= 1'b1;
            rd_valid  <= 1'b0;
            hit       <= 1'b0;
            valid_out <= 1'b0;
          end
        end
        SWEEP: begin
          valid[flush_idx] <= 1'b0;
          rd_valid         <= 1'b0;
          wl_err           <= 1'b0;
          hit              <= 1'b0;
          if (flush_idx == IDX_W'(DEPTH - 1)) begin
            flush_idx <= '0;
            state     <= IDLE;
            busy      <= 1'b0;
          end else begin
            flush_idx <= flush_idx + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tag_data_array.sv
// Directed bench for tag_data_array: reads, writes, invalidate, illegal
// wordlines, flush sweep length and asynchronous reset during a sweep.
module tb_tag_data_array;

  logic        clk = 1'b0;
  logic        reset;
  logic        we, inv, flush;
  logic [15:0] wl;
  logic [3:0]  tag_in;
  logic [7:0]  data_in;
  logic [3:0]  tag_out;
  logic [7:0]  data_out;
  logic        valid_out, hit, rd_valid, wl_err, busy;

  int checks   = 0;
  int failures = 0;

  tag_data_array #(.DEPTH(16), .TAG_W(4), .DATA_W(8)) dut (
    .clk(clk), .reset(reset), .we(we), .inv(inv), .flush(flush), .wl(wl),
    .tag_in(tag_in), .data_in(data_in), .tag_out(tag_out), .data_out(data_out),
    .valid_out(valid_out), .hit(hit), .rd_valid(rd_valid), .wl_err(wl_err),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, clock it in, then sample 1ns after the edge.
  task automatic cyc(input logic [15:0] w, input logic we_v, input logic inv_v,
                     input logic fl_v, input logic [3:0] t, input logic [7:0] d);
    wl = w; we = we_v; inv = inv_v; flush = fl_v; tag_in = t; data_in = d;
    @(posedge clk);
    #1;
    we = 1'b0; inv = 1'b0; flush = 1'b0;
  endtask

  int n;

  initial begin
    reset = 1'b1; we = 0; inv = 0; flush = 0; wl = '0; tag_in = '0; data_in = '0;
    #12;
    chk("rst_tag", 32'(tag_out), 0);
    chk("rst_data", 32'(data_out), 0);
    chk("rst_flags", {valid_out, hit, rd_valid, wl_err, busy}, 0);
    reset = 1'b0;

    cyc(16'h0020, 0, 0, 0, 4'h0, 8'h00);
    chk("rd5_flags", {rd_valid, valid_out, hit, wl_err}, 4'b1000);

    cyc(16'h0008, 1, 0, 0, 4'hA, 8'h5C);
    chk("wr3_tag", 32'(tag_out), 32'hA);
    chk("wr3_data", 32'(data_out), 32'h5C);
    chk("wr3_vh", {valid_out, hit, rd_valid}, 3'b111);

    cyc(16'h0008, 0, 0, 0, 4'hB, 8'h00);
    chk("rd3_miss", {valid_out, hit}, 2'b10);
    chk("rd3_data", 32'(data_out), 32'h5C);

    cyc(16'h0001, 1, 0, 0, 4'h1, 8'h11);
    cyc(16'h8000, 1, 0, 0, 4'hF, 8'hFF);
    cyc(16'h0001, 0, 0, 0, 4'h1, 8'h00);
    chk("rd0", {tag_out, data_out, valid_out, hit}, {4'h1, 8'h11, 2'b11});
    cyc(16'h8000, 0, 0, 0, 4'hF, 8'h00);
    chk("rd15", {tag_out, data_out, valid_out, hit}, {4'hF, 8'hFF, 2'b11});

    cyc(16'h8000, 1, 1, 0, 4'h3, 8'h00);
    chk("inv15_out", {tag_out, data_out, valid_out, hit}, {4'hF, 8'hFF, 2'b00});
    cyc(16'h8000, 0, 0, 0, 4'hF, 8'h00);
    chk("rd15_after_inv", {tag_out, data_out, valid_out, hit, rd_valid}, {4'hF, 8'hFF, 3'b001});

    cyc(16'h0000, 0, 0, 0, 4'h0, 8'h00);
    chk("wl0_err", {wl_err, rd_valid, hit, valid_out}, 4'b1000);
    chk("wl0_hold", {tag_out, data_out}, {4'hF, 8'hFF});
    cyc(16'h0011, 1, 0, 0, 4'h7, 8'h77);
    chk("wlmulti_err", {wl_err, rd_valid, hit, valid_out}, 4'b1000);
    chk("wlmulti_hold", {tag_out, data_out}, {4'hF, 8'hFF});
    cyc(16'h0001, 0, 0, 0, 4'h1, 8'h00);
    chk("rd0_nowrite", {tag_out, data_out, valid_out, hit, wl_err}, {4'h1, 8'h11, 3'b110});
    cyc(16'h0010, 0, 0, 0, 4'h7, 8'h00);
    chk("rd4_nowrite", {valid_out, hit, rd_valid}, 3'b001);

    for (int i = 0; i < 16; i++) cyc(16'(1) << i, 1, 0, 0, 4'(i), 8'h20 + 8'(i));
    cyc(16'h0004, 0, 0, 0, 4'h2, 8'h00);
    chk("fill_rd2", {tag_out, data_out, valid_out, hit}, {4'h2, 8'h22, 2'b11});

    cyc(16'h0004, 0, 0, 1, 4'h2, 8'h00);
    n = 0;
    while (busy && n < 40) begin
      n++;
      chk("sweep_quiet", {rd_valid, wl_err, hit}, 3'b000);
      if (n == 5) cyc(16'h0004, 1, 0, 0, 4'h9, 8'h99);
      else cyc(16'h0004, 0, 0, 0, 4'h2, 8'h00);
    end
    chk("sweep_len", 32'(n), 16);
    for (int i = 0; i < 16; i++) begin
      cyc(16'(1) << i, 0, 0, 0, 4'(i), 8'h00);
      chk($sformatf("post_flush_%0d", i),
          {tag_out, data_out, valid_out, hit, rd_valid}, {4'(i), 8'h20 + 8'(i), 3'b001});
    end

    cyc(16'h0002, 1, 0, 0, 4'h1, 8'h31);
    cyc(16'h0200, 1, 0, 0, 4'h9, 8'h39);
    chk("pre_rst_wr9", {valid_out, hit}, 2'b11);
    cyc(16'h0000, 0, 0, 1, 4'h0, 8'h00);
    chk("flush2_busy", 32'(busy), 1);
    for (int i = 0; i < 6; i++) cyc(16'h0000, 0, 0, 0, 4'h0, 8'h00);
    #3 reset = 1'b1;
    #1;
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_outs", {tag_out, data_out, valid_out, hit, rd_valid, wl_err}, 0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 16; i++) begin
      cyc(16'(1) << i, 0, 0, 0, 4'h9, 8'h00);
      chk($sformatf("post_rst_%0d", i), {valid_out, hit, rd_valid, busy}, 4'b0010);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tag_data_array.md
Name: tag_data_array

Overview:
- Parametrised tag+data storage array, one entry selected by a one-hot wordline.
- Adds the following to the original 16x(4+8) array:
  - per-entry valid bits
  - registered reads with a tag-compare hit flag
  - single-entry invalidate
  - multi-cycle flush sweep
  - illegal-wordline detection
- Sits below the cache controller; the controller drives the one-hot wordlines and consumes hit/data.

Parameters:
- DEPTH, 16, number of entries; also the wordline width. Must be ≥2.
- TAG_W, 4, tag field width in bits.
- DATA_W, 8, data field width in bits.
- Derived localparam IDX_W = $clog2(DEPTH), not overridable.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- we  in  1  write the selected entry (tag, data, valid=1).
- inv  in  1  clear the valid bit of the selected entry.
- flush  in  1  start a sweep that clears all valid bits.
- wl  in  DEPTH  one-hot wordline; bit i selects entry i.
- tag_in  in  TAG_W  write tag, and compare tag for the hit check.
- data_in  in  DATA_W  write data.
- tag_out  out  TAG_W  registered stored tag of the selected entry.
- data_out  out  DATA_W  registered stored data of the selected entry.
- valid_out  out  1  registered valid bit of the selected entry.
- hit  out  1  registered: valid_out & (stored tag == tag_in of the access cycle).
- rd_valid  out  1  registered; 1 when the outputs reflect a legal access issued in the previous cycle.
- wl_err  out  1  registered; 1 when the previous cycle's wl was zero or multi-hot.
- busy  out  1  high while the flush sweep runs.

Behaviour:
- **Reset (async, reset=1)**
  - All valid bits cleared.
  - tag_out, data_out, valid_out, hit, rd_valid, wl_err all = 0.
  - busy = 0; FSM goes to IDLE; flush index = 0.
  - Tag/data arrays are not reset.
  - Reset mid-flush aborts the sweep; all valids are still cleared, by reset itself.
- **Wordline decode**
  - Combinational one-hot check plus one-hot-to-index encode.
  - A cycle is legal when wl has exactly one bit set and busy=0.
- **Legal cycle, no command**
  - Read access.
  - Next cycle: tag_out/data_out/valid_out show entry[idx], hit = valid & tag match, rd_valid=1, wl_err=0.
- **Legal cycle with we=1, inv=0**
  - At the edge, entry[idx] tag←tag_in, data←data_in, valid←1.
  - Write-first: next-cycle outputs show the new values, and hit=1.
- **Legal cycle with inv=1**
  - valid[idx]←0; the write is suppressed even if we=1 (inv has priority).
  - Next cycle: valid_out=0, hit=0; tag/data outputs show the stored, unchanged contents.
- **Illegal wl (zero or multi-hot), busy=0**
  - No array or valid change.
  - Next cycle: wl_err=1, rd_valid=0, hit=0, valid_out=0; tag_out/data_out hold their previous values.
- **Flush FSM**
  - States are IDLE and SWEEP.
  - IDLE → SWEEP when flush=1 and busy=0.
    - That same cycle's we/inv/read is ignored.
    - The index is loaded with 0, and busy goes to 1 at the next edge.
  - In SWEEP, each cycle: valid[index]←0, index+1.
  - When index == DEPTH-1, clear it, go to IDLE, and busy returns to 0.
  - Sweep length: exactly DEPTH busy cycles.
- **While busy=1**
  - we/inv/flush/read are ignored.
  - rd_valid=0, wl_err=0, hit=0; tag_out/data_out/valid_out hold their values.
  - The first accepted access is in the cycle where busy is seen 0.
- **Output registers**
  - All outputs except busy update only on legal, illegal-wl, or flush-idle transitions as listed above.
  - There are no combinational paths from inputs to outputs.

Test Plan:
- Reset then a legal read of entry 5 (wl=16'h0020) → next cycle: rd_valid=1, valid_out=0, hit=0, wl_err=0.
- Write entry 3 (wl=16'h0008, we=1, tag_in=4'hA, data_in=8'h5C) → next cycle: tag_out=A, data_out=5C, valid_out=1, hit=1. Then read entry 3 with tag_in=4'hB → hit=0, valid_out=1, data_out=5C.
- Write entries 0 and 15 with tag 1/data 11 and tag F/data FF, then read both → correct values, hit=1 with matching tag. Then inv=1 with we=1 on entry 15 → data unchanged (FF), valid_out=0 on the following read.
- wl=16'h0000, then wl=16'h0011 with we=1 → wl_err=1 and rd_valid=0 on each following cycle. A later read of entries 0 and 4 shows no write occurred (entry 0 still tag 1/data 11).
- Fill all 16 entries, pulse flush for 1 cycle →
  - busy high for exactly 16 cycles
  - we asserted mid-sweep has no effect
  - then every entry reads valid_out=0, hit=0, with tag/data retained.
- Start a flush, assert reset asynchronously (between edges) at sweep cycle 7 → busy=0 and all outputs 0 immediately. After deassertion, all 16 entries read valid_out=0.
